logic_gate_unit: RTL and testbench

//  Parametrised, registered successor to the 2-input AND gate.

---
 rtl/logic_gate_unit_if.sv | 26 ++
 rtl/logic_gate_unit.sv | 149 ++++++++++++++
 tb/tb_logic_gate_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_gate_unit_if.sv
// Handshake bundle for logic_gate_unit: operand beats in, registered results out.
interface logic_gate_unit_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 2
);
    logic [2:0]             op;
    logic                   acc_mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*LANES-1:0] in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;

    modport master (
        output op, acc_mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  op, acc_mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered multi-lane bitwise gate with run-time op select and optional
// per-packet accumulation; one output register, full 1 beat/cycle throughput.
module lgu_fold_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] and_i,
    input  logic [WIDTH-1:0] or_i,
    input  logic [WIDTH-1:0] xor_i,
    output logic [WIDTH-1:0] and_o,
    output logic [WIDTH-1:0] or_o,
    output logic [WIDTH-1:0] xor_o
);
    assign and_o = and_i & operand;
    assign or_o  = or_i  | operand;
    assign xor_o = xor_i ^ operand;
endmodule

module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic              clk,
    input  logic              rst,
    logic_gate_unit_if.slave  bus
);
    typedef enum logic [0:0] {S_IDLE, S_ACCUM} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [2:0]         op_q, op_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;

    // Running reductions across lanes; element k holds the fold of lanes 0..k.
    logic [LANES-1:0][WIDTH-1:0] and_c, or_c, xor_c;
    logic [WIDTH-1:0]            lane0;

    assign lane0    = bus.in_data[WIDTH-1:0];
    assign and_c[0] = lane0;
    assign or_c[0]  = lane0;
    assign xor_c[0] = lane0;

    for (genvar k = 1; k < LANES; k++) begin : g_lane
        lgu_fold_stage #(.WIDTH(WIDTH)) u_stage (
            .operand (bus.in_data[k*WIDTH +: WIDTH]),
            .and_i   (and_c[k-1]),
            .or_i    (or_c[k-1]),
            .xor_i   (xor_c[k-1]),
            .and_o   (and_c[k]),
            .or_o    (or_c[k]),
            .xor_o   (xor_c[k])
        );
    end

    logic             accept;
    logic             emit;
    logic [2:0]       eff_op;
    logic [WIDTH-1:0] beat_base;
    logic [WIDTH-1:0] acc_next;
    logic             invert;

    assign bus.in_ready  = !rst && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Mid-packet op changes are ignored: ACCUM works from the op latched on the first beat.
    // ACCUM is only entered with acc_mode=1, so the state itself carries the latched mode.
    always_comb begin
        eff_op = (state_q == S_ACCUM) ? op_q : bus.op;

        case (eff_op)
            3'd0, 3'd3: beat_base = and_c[LANES-1];
            3'd1, 3'd4: beat_base = or_c[LANES-1];
            3'd2, 3'd5: beat_base = xor_c[LANES-1];
            default:    beat_base = lane0;
        endcase

        if (state_q == S_ACCUM) begin
            case (eff_op)
                3'd0, 3'd3: acc_next = acc_q & beat_base;
                3'd1, 3'd4: acc_next = acc_q | beat_base;
                3'd2, 3'd5: acc_next = acc_q ^ beat_base;
                default:    acc_next = beat_base;
            endcase
        end else begin
            acc_next = beat_base;
        end

        invert = (eff_op == 3'd3) || (eff_op == 3'd4) ||
                 (eff_op == 3'd5) || (eff_op == 3'd7);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        emit        = 1'b0;

        if (accept) begin
            if (state_q == S_IDLE) begin
                if (!bus.acc_mode) begin
                    emit = 1'b1;
                end else begin
                    acc_d = acc_next;
                    op_d  = bus.op;
                    if (bus.in_last) emit = 1'b1;
                    else             state_d = S_ACCUM;
                end
            end else begin
                acc_d = acc_next;
                if (bus.in_last) begin
                    emit    = 1'b1;
                    state_d = S_IDLE;
                end
            end
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = invert ? ~acc_next : acc_next;
            out_last_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit (WIDTH=8, LANES=2) with hand-computed expectations.
module tb_logic_gate_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic_gate_unit_if #(.WIDTH(8), .LANES(2)) bus ();

    logic_gate_unit #(.WIDTH(8), .LANES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Rows: op 0..7; columns: lane pairs (00,FF),(FF,00),(FF,FF),(00,00).
    logic [7:0] truth_exp [0:7][0:3] = '{
        '{8'h00, 8'h00, 8'hFF, 8'h00},
        '{8'hFF, 8'hFF, 8'hFF, 8'h00},
        '{8'hFF, 8'hFF, 8'h00, 8'h00},
        '{8'hFF, 8'hFF, 8'h00, 8'hFF},
        '{8'h00, 8'h00, 8'h00, 8'hFF},
        '{8'h00, 8'h00, 8'hFF, 8'hFF},
        '{8'h00, 8'hFF, 8'hFF, 8'h00},
        '{8'hFF, 8'h00, 8'h00, 8'hFF}
    };
    logic [7:0] pair_l0 [0:3] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] pair_l1 [0:3] = '{8'hFF, 8'h00, 8'hFF, 8'h00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic am, input logic [7:0] l0,
                         input logic [7:0] l1, input logic last);
        bus.op       = o;
        bus.acc_mode = am;
        bus.in_data  = {l1, l0};
        bus.in_last  = last;
        bus.in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        drive(3'd0, 1'b0, 8'hFF, 8'hFF, 1'b0);
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 8'h00) begin
            failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_truth_sweep();
        bus.out_ready = 1'b1;
        for (int o = 0; o < 8; o++) begin
            for (int p = 0; p < 4; p++) begin
                drive(3'(o), 1'b0, pair_l0[p], pair_l1[p], 1'b0);
                tick();
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 ||
                    bus.out_data !== truth_exp[o][p]) begin
                    failures++;
                    $display("FAIL truth op=%0d pair=%0d got v=%b l=%b d=%h exp v=1 l=1 d=%h",
                             o, p, bus.out_valid, bus.out_last, bus.out_data, truth_exp[o][p]);
                end
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL consume_clears_valid got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_single_and();
        drive(3'd0, 1'b0, 8'hF0, 8'h3C, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_data !== 8'h30) begin
            failures++;
            $display("FAIL single_and got v=%b l=%b d=%h exp v=1 l=1 d=30",
                     bus.out_valid, bus.out_last, bus.out_data);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(3'd1, 1'b0, 8'h01, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_data !== 8'h30 || bus.out_last !== 1'b1) begin
                failures++;
                $display("FAIL hold cyc=%0d got rdy=%b v=%b d=%h exp rdy=0 v=1 d=30",
                         i, bus.in_ready, bus.out_valid, bus.out_data);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h03) begin
            failures++;
            $display("FAIL release_beat got v=%b d=%h exp v=1 d=03", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_accumulate();
        bus.out_ready = 1'b1;
        drive(3'd2, 1'b1, 8'h01, 8'h02, 1'b0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL acc_xor_beat1 got v=%b exp v=0", bus.out_valid);
        end
        drive(3'd2, 1'b1, 8'h04, 8'h08, 1'b0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL acc_xor_beat2 got v=%b exp v=0", bus.out_valid);
        end
        drive(3'd2, 1'b1, 8'h10, 8'h00, 1'b1);
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_data !== 8'h1F) begin
            failures++;
            $display("FAIL acc_xor_result got v=%b l=%b d=%h exp v=1 l=1 d=1F",
                     bus.out_valid, bus.out_last, bus.out_data);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL acc_single_result got v=%b exp v=0", bus.out_valid);
        end
        drive(3'd3, 1'b1, 8'hFF, 8'hFF, 1'b0);
        tick();
        // Op switches to OR mid-packet; the latched NAND must still apply.
        drive(3'd1, 1'b1, 8'hFF, 8'h7F, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h80) begin
            failures++;
            $display("FAIL acc_nand_result got v=%b d=%h exp v=1 d=80", bus.out_valid, bus.out_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        bus.out_ready = 1'b1;
        drive(3'd2, 1'b1, 8'h05, 8'h00, 1'b0);
        tick();
        drive(3'd2, 1'b1, 8'h0A, 8'h00, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_out got v=%b d=%h exp v=0 d=00", bus.out_valid, bus.out_data);
        end
        rst = 1'b0;
        drive(3'd2, 1'b1, 8'h03, 8'h00, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h03) begin
            failures++;
            $display("FAIL post_reset_packet got v=%b d=%h exp v=1 d=03", bus.out_valid, bus.out_data);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL no_stale_output got v=%b exp v=0", bus.out_valid);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.op        = 3'd0;
        bus.acc_mode  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        test_reset();
        test_truth_sweep();
        test_single_and();
        test_backpressure();
        test_accumulate();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
